// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Define PS2_TX_TIMEOUT_EN to include the device-clock watchdog.

module ps2_tx_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk25,
    input  logic rst,
    input  logic pin,
    output logic level
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] run;

    // level only follows s2 after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk25) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            run   <= '0;
            level <= 1'b1;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == level) begin
                run <= '0;
            end else if (run == CW'(FILTER_LEN - 1)) begin
                level <= s2;
                run   <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end
endmodule

module ps2_host_tx #(
    parameter int CLK_HZ         = 25000000,
    parameter int INHIBIT_CYCLES = CLK_HZ / 10000,
    parameter int START_HOLD     = 32,
    parameter int TIMEOUT_CYCLES = (CLK_HZ / 1000) * 15,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    // state     | meaning
    // IDLE      | lines released, waiting for a request
    // INHIBIT   | clock held low to claim the bus
    // START     | clock and data low (start bit)
    // SHIFT     | clock released, one frame bit per device clock fall
    // ACK       | waiting for the device ack fall
    // WAIT_IDLE | waiting for both lines to float high
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam int TMR_MAX = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [9:0]       frame, frame_nxt;
    logic [3:0]       bit_cnt, cnt_nxt;
    logic             clk_oe_nxt, dat_oe_nxt, done_nxt, err_nxt;
    logic             clk_filt, dat_filt, clk_filt_d, fall;

    ps2_tx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk25 (clk25),
        .rst   (rst),
        .pin   (ps2_clk_in),
        .level (clk_filt)
    );

    ps2_tx_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk25 (clk25),
        .rst   (rst),
        .pin   (ps2_dat_in),
        .level (dat_filt)
    );

    assign fall = clk_filt_d & ~clk_filt;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            watch;

    assign watch = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

    // restarted on entry to SHIFT and on every device clock fall
    always_ff @(posedge clk25) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state == START && state_nxt == SHIFT) || (watch && fall)) begin
            to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if (watch && to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr;
        frame_nxt  = frame;
        cnt_nxt    = bit_cnt;
        clk_oe_nxt = ps2_clk_oe;
        dat_oe_nxt = ps2_dat_oe;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_nxt = 1'b0;
                dat_oe_nxt = 1'b0;
                if (tx_valid) begin
                    frame_nxt  = {1'b1, ~^tx_data, tx_data};
                    tmr_nxt    = TMR_W'(INHIBIT_CYCLES - 1);
                    clk_oe_nxt = 1'b1;
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (tmr == '0) begin
                    tmr_nxt    = TMR_W'(START_HOLD - 1);
                    dat_oe_nxt = 1'b1;
                    state_nxt  = START;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            START: begin
                if (tmr == '0) begin
                    clk_oe_nxt = 1'b0;
                    cnt_nxt    = 4'd0;
                    state_nxt  = SHIFT;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            SHIFT: begin
                if (fall) begin
                    dat_oe_nxt = ~frame[0];
                    frame_nxt  = {1'b0, frame[9:1]};
                    cnt_nxt    = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    if (dat_filt) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && dat_filt) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (watch && to_cnt == '0) begin
            err_nxt   = 1'b1;
            done_nxt  = 1'b0;
            state_nxt = IDLE;
        end
`endif
        // every path back to IDLE releases both lines on the same edge
        if (state_nxt == IDLE) begin
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            frame      <= '0;
            bit_cnt    <= 4'd0;
            clk_filt_d <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            frame      <= frame_nxt;
            bit_cnt    <= cnt_nxt;
            clk_filt_d <= clk_filt;
            ps2_clk_oe <= clk_oe_nxt;
            ps2_dat_oe <= dat_oe_nxt;
            tx_ready   <= (state_nxt == IDLE);
            tx_busy    <= (state_nxt != IDLE);
            tx_done    <= done_nxt;
            tx_err     <= err_nxt;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain keyboard model clocks frames out of the host,
// and each observed frame is compared with one computed from the byte's bits and parity.
module tb_ps2_host_tx;
    localparam int INH  = 2500;
    localparam int HOLD = 32;
    localparam int TMO  = 4000;
    localparam int FLT  = 4;
    localparam int HALF = 20;

    logic       clk25    = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [9:0] obs;
    int         fall_cyc [1:11];

    // wired-AND open-drain lines
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .CLK_HZ         (25000000),
        .INHIBIT_CYCLES (INH),
        .START_HOLD     (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk25      (clk25),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    always @(negedge clk25) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // dat_oe after falls 1..10: inverted data bits LSB first, inverted odd parity, released stop
    function automatic logic [9:0] model_oe(input logic [7:0] d);
        logic [9:0] v;
        int         ones;
        ones = 0;
        v    = '0;
        for (int i = 0; i < 8; i++) begin
            v[i] = ~d[i];
            ones += int'(d[i]);
        end
        v[8] = ((ones % 2) == 1);
        v[9] = 1'b0;
        return v;
    endfunction

    task automatic launch(input logic [7:0] d, input bit keep, input logic [7:0] nxt);
        @(negedge clk25);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk25);
        if (keep) tx_data = nxt;
        else tx_valid = 1'b0;
    endtask

    // entered on the negedge right after the accept edge
    task automatic phase_timing();
        int n;
        int m;
        bit held;
        n    = 0;
        m    = 0;
        held = 1'b1;
        check("clk_oe_after_accept", int'(ps2_clk_oe), 1);
        check("busy_after_accept", int'(tx_busy), 1);
        while (!ps2_dat_oe && n < INH + 50) begin
            @(negedge clk25);
            n++;
            if (!ps2_clk_oe) held = 1'b0;
        end
        check("inhibit_len", n, INH);
        check("clk_held_inhibit", int'(held), 1);
        while (ps2_clk_oe && m < HOLD + 50) begin
            @(negedge clk25);
            m++;
        end
        check("start_hold_len", m, HOLD);
        check("dat_oe_at_release", int'(ps2_dat_oe), 1);
    endtask

    task automatic run_device(input int nfalls, input bit ack_low);
        obs = '0;
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11) dev_dat = ~ack_low;
            repeat (HALF) @(negedge clk25);
            dev_clk     = 1'b0;
            fall_cyc[i] = cyc;
            repeat (HALF - 2) @(negedge clk25);
            if (i <= 10) obs[i-1] = ps2_dat_oe;
            repeat (2) @(negedge clk25);
            dev_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk25);
        dev_dat = 1'b1;
    endtask

    task automatic finish_frame(input string tag, input int d0, input int e0,
                                input int exp_done, input int exp_err);
        repeat (40) @(negedge clk25);
        check({tag, "_done_pulses"}, done_cnt - d0, exp_done);
        check({tag, "_err_pulses"}, err_cnt - e0, exp_err);
        check({tag, "_ready"}, int'(tx_ready), 1);
        check({tag, "_busy"}, int'(tx_busy), 0);
        check({tag, "_clk_oe"}, int'(ps2_clk_oe), 0);
        check({tag, "_dat_oe"}, int'(ps2_dat_oe), 0);
    endtask

    task automatic frame_ok(input logic [7:0] d, input string tag);
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        launch(d, 1'b0, 8'h00);
        phase_timing();
        run_device(11, 1'b1);
        check({tag, "_frame"}, int'(obs), int'(model_oe(d)));
        finish_frame(tag, d0, e0, 1, 0);
    endtask

    initial begin
        int d0;
        int e0;
        int w;
        logic [7:0] rb;

        repeat (3) @(negedge clk25);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_dat_oe", int'(ps2_dat_oe), 0);
        check("rst_done", int'(tx_done), 0);
        check("rst_err", int'(tx_err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk25);

        frame_ok(8'hF4, "f4");
        check("f4_literal", int'(obs), int'(10'b01_0000_1011));

        frame_ok(8'hED, "ed");
        check("ed_parity_oe", int'(obs[8]), 0);

        // device leaves data high on the ack fall
        d0 = done_cnt;
        e0 = err_cnt;
        launch(8'h12, 1'b0, 8'h00);
        phase_timing();
        run_device(11, 1'b0);
        check("nack_frame", int'(obs), int'(model_oe(8'h12)));
        finish_frame("nack", d0, e0, 0, 1);

        // device stops clocking after fall 4
        d0 = done_cnt;
        e0 = err_cnt;
        launch(8'h5A, 1'b0, 8'h00);
        phase_timing();
        run_device(4, 1'b1);
`ifdef PS2_TX_TIMEOUT_EN
        w = 0;
        while (!tx_err && w < TMO + 100) begin
            @(negedge clk25);
            w++;
        end
        check("timeout_delay", cyc - fall_cyc[4], 2 + FLT + 1 + TMO);
        check("timeout_clk_oe", int'(ps2_clk_oe), 0);
        check("timeout_dat_oe", int'(ps2_dat_oe), 0);
        check("timeout_busy", int'(tx_busy), 0);
        finish_frame("timeout", d0, e0, 0, 1);
`else
        repeat (TMO + 1000) @(negedge clk25);
        check("no_timeout_busy", int'(tx_busy), 1);
        check("no_timeout_err", err_cnt - e0, 0);
        rst = 1'b1;
        @(negedge clk25);
        rst = 1'b0;
        repeat (5) @(negedge clk25);
`endif

        // reset in the middle of SHIFT
        launch(8'h3C, 1'b0, 8'h00);
        phase_timing();
        run_device(5, 1'b1);
        rst = 1'b1;
        @(negedge clk25);
        check("midrst_clk_oe", int'(ps2_clk_oe), 0);
        check("midrst_dat_oe", int'(ps2_dat_oe), 0);
        check("midrst_busy", int'(tx_busy), 0);
        check("midrst_ready", int'(tx_ready), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk25);
        frame_ok(8'h00, "zero");
        check("zero_parity_oe", int'(obs[8]), 0);

        // request held with 0x55 throughout the 0xAA transfer
        d0 = done_cnt;
        e0 = err_cnt;
        launch(8'hAA, 1'b1, 8'h55);
        phase_timing();
        run_device(11, 1'b1);
        check("hold_aa_frame", int'(obs), int'(model_oe(8'hAA)));
        w = 0;
        while (!tx_done && w < 200) begin
            @(negedge clk25);
            w++;
        end
        check("hold_aa_done", int'(tx_done), 1);
        check("hold_ready_at_done", int'(tx_ready), 1);
        check("hold_clk_oe_at_done", int'(ps2_clk_oe), 0);
        @(negedge clk25);
        tx_valid = 1'b0;
        phase_timing();
        run_device(11, 1'b1);
        check("hold_55_frame", int'(obs), int'(model_oe(8'h55)));
        finish_frame("hold", d0, e0, 2, 0);

        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255));
            frame_ok(rb, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
